// File: rtl/perceptron_core.sv
// rtl/perceptron_core.sv - 16-input bit-serial perceptron with online training and inference
//
// Purpose: one weight per pixel plus a bias, all in registers. Each operation
// accumulates bias + sum(w[i] for set pixels) one pixel per cycle, classifies by
// the sign of the sum, and on a training mistake nudges the bias and the active
// weights toward the label with saturating arithmetic.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   learn, learn_x, learn_is_O training stream (level enable, pattern, label)
//   infer_start, infer_x       1-cycle inference request and its pattern
//   clear_weights              synchronous clear of weights, bias, counters
//   busy                       operation in progress
//   infer_valid, infer_is_O    inference result pulse and held class
//   score                      signed sum of the last completed operation
//   learn_done, mistake        training done pulse and held mistake flag
//   update_count, error_count  saturating sample and mistake counters
module perceptron_core #(
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 13,
  parameter int LR        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 learn,
  input  logic [15:0]          learn_x,
  input  logic                 learn_is_O,
  input  logic                 infer_start,
  input  logic [15:0]          infer_x,
  input  logic                 clear_weights,
  output logic                 busy,
  output logic                 infer_valid,
  output logic                 infer_is_O,
  output logic [ACC_WIDTH-1:0] score,
  output logic                 learn_done,
  output logic                 mistake,
  output logic [15:0]          update_count,
  output logic [15:0]          error_count
);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DECIDE, S_UPDATE, S_DONE} state_e;

  localparam logic signed [W_WIDTH:0] W_MAX = (W_WIDTH+1)'(2**(W_WIDTH-1) - 1);
  localparam logic signed [W_WIDTH:0] W_MIN = (W_WIDTH+1)'(-(2**(W_WIDTH-1)));
  localparam logic signed [W_WIDTH:0] STEP  = (W_WIDTH+1)'(LR);

  state_e                      state_q, state_d;
  logic [3:0]                  idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]                 pat_q, pat_d;
  logic                        lbl_q, lbl_d;
  logic                        train_q, train_d;
  logic                        miss_q, miss_d;
  logic signed [W_WIDTH-1:0]   w_q [16];
  logic signed [W_WIDTH-1:0]   w_d [16];
  logic signed [W_WIDTH-1:0]   bias_q, bias_d;
  logic signed [ACC_WIDTH-1:0] score_q, score_d;
  logic                        is_o_q, is_o_d;
  logic                        mistake_q, mistake_d;
  logic [15:0]                 upd_cnt_q, upd_cnt_d;
  logic [15:0]                 err_cnt_q, err_cnt_d;
  logic                        learn_prev_q;
  logic [16:0]                 last_pair_q, last_pair_d;
  logic                        last_vld_q, last_vld_d;
  logic                        trig;
  logic                        pred_o;

  // Step a weight by +LR (up=1) or -LR, clamping instead of wrapping.
  function automatic logic signed [W_WIDTH-1:0] sat_step(input logic signed [W_WIDTH-1:0] v,
                                                         input logic up);
    logic signed [W_WIDTH:0] ext;
    logic signed [W_WIDTH:0] s;
    ext = $signed({v[W_WIDTH-1], v});
    s   = up ? (ext + STEP) : (ext - STEP);
    if (s > W_MAX)      s = W_MAX;
    else if (s < W_MIN) s = W_MIN;
    return $signed(s[W_WIDTH-1:0]);
  endfunction

  // A held learn level updates once; a new pair or a fresh rising level retriggers.
  assign trig   = learn && (!learn_prev_q || !last_vld_q || ({learn_x, learn_is_O} != last_pair_q));
  assign pred_o = ~acc_q[ACC_WIDTH-1];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    pat_d       = pat_q;
    lbl_d       = lbl_q;
    train_d     = train_q;
    miss_d      = miss_q;
    w_d         = w_q;
    bias_d      = bias_q;
    score_d     = score_q;
    is_o_d      = is_o_q;
    mistake_d   = mistake_q;
    upd_cnt_d   = upd_cnt_q;
    err_cnt_d   = err_cnt_q;
    last_pair_d = last_pair_q;
    last_vld_d  = last_vld_q;
    learn_done  = 1'b0;
    infer_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          pat_d       = learn_x;
          lbl_d       = learn_is_O;
          train_d     = 1'b1;
          last_pair_d = {learn_x, learn_is_O};
          last_vld_d  = 1'b1;
        end else if (infer_start) begin
          pat_d   = infer_x;
          lbl_d   = 1'b0;
          train_d = 1'b0;
        end
        if (trig || infer_start) begin
          acc_d   = ACC_WIDTH'(bias_q);
          idx_d   = 4'd0;
          miss_d  = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (pat_q[idx_q]) acc_d = acc_q + ACC_WIDTH'(w_q[idx_q]);
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        score_d = acc_q;
        idx_d   = 4'd0;
        state_d = S_DONE;
        if (!train_q) begin
          is_o_d = pred_o;
        end else if (pred_o != lbl_q) begin
          miss_d  = 1'b1;
          bias_d  = sat_step(bias_q, lbl_q);
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (pat_q[idx_q]) w_d[idx_q] = sat_step(w_q[idx_q], lbl_q);
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        if (train_q) begin
          learn_done = 1'b1;
          mistake_d  = miss_q;
          if (upd_cnt_q != 16'hFFFF) upd_cnt_d = upd_cnt_q + 16'd1;
          if (miss_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        end else begin
          infer_valid = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear aborts whatever is running, so the pulses of that cycle are suppressed too.
    if (clear_weights) begin
      for (int i = 0; i < 16; i++) w_d[i] = '0;
      bias_d      = '0;
      score_d     = '0;
      mistake_d   = 1'b0;
      upd_cnt_d   = '0;
      err_cnt_d   = '0;
      last_pair_d = '0;
      last_vld_d  = 1'b0;
      state_d     = S_IDLE;
      learn_done  = 1'b0;
      infer_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      pat_q        <= '0;
      lbl_q        <= 1'b0;
      train_q      <= 1'b0;
      miss_q       <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      bias_q       <= '0;
      score_q      <= '0;
      is_o_q       <= 1'b0;
      mistake_q    <= 1'b0;
      upd_cnt_q    <= '0;
      err_cnt_q    <= '0;
      learn_prev_q <= 1'b0;
      last_pair_q  <= '0;
      last_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      pat_q        <= pat_d;
      lbl_q        <= lbl_d;
      train_q      <= train_d;
      miss_q       <= miss_d;
      w_q          <= w_d;
      bias_q       <= bias_d;
      score_q      <= score_d;
      is_o_q       <= is_o_d;
      mistake_q    <= mistake_d;
      upd_cnt_q    <= upd_cnt_d;
      err_cnt_q    <= err_cnt_d;
      learn_prev_q <= learn;
      last_pair_q  <= last_pair_d;
      last_vld_q   <= last_vld_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign infer_is_O   = is_o_q;
  assign score        = score_q;
  assign mistake      = mistake_q;
  assign update_count = upd_cnt_q;
  assign error_count  = err_cnt_q;

endmodule
